// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS controller and its ALU decoder.
package cpu_ctrl_pkg;

    localparam int unsigned OP_W    = 6;
    localparam int unsigned FUNCT_W = 6;
    localparam int unsigned STATE_W = 4;

    typedef enum logic [STATE_W-1:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTE  = 4'd6,
        S_ALUWB    = 4'd7,
        S_BRANCH   = 4'd8,
        S_ADDIEXEC = 4'd9,
        S_ADDIWB   = 4'd10
    } state_t;

    // ALU operation class handed from the FSM to the ALU decoder.
    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } aluop_t;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;

    localparam logic [FUNCT_W-1:0] FUNCT_ADD = 6'b100000;
    localparam logic [FUNCT_W-1:0] FUNCT_SUB = 6'b100010;
    localparam logic [FUNCT_W-1:0] FUNCT_AND = 6'b100100;
    localparam logic [FUNCT_W-1:0] FUNCT_OR  = 6'b100101;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_OR  = 2'b11;

    localparam logic [1:0] SRCB_B      = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

endpackage

// File: rtl/alu_op_decoder.sv
// Maps the FSM's ALU operation class plus the R-type funct field onto an ALU control code.
module alu_op_decoder
    import cpu_ctrl_pkg::*;
(
    input  logic [1:0] aluOp,
    input  logic [5:0] funct,
    output logic [1:0] aluControl,
    output logic       functIllegal
);

    // Unsupported funct values fall back to ADD and are flagged.
    always_comb begin
        aluControl   = ALU_ADD;
        functIllegal = 1'b0;
        case (aluOp)
            ALUOP_SUB:   aluControl = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct)
                    FUNCT_ADD: aluControl = ALU_ADD;
                    FUNCT_SUB: aluControl = ALU_SUB;
                    FUNCT_AND: aluControl = ALU_AND;
                    FUNCT_OR:  aluControl = ALU_OR;
                    default:   functIllegal = 1'b1;
                endcase
            end
            default:     aluControl = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multicycle MIPS controller: Moore FSM driving datapath strobes, ALU decode and interrupt latch.
module multicycle_control_unit
    import cpu_ctrl_pkg::*;
#(
    parameter int unsigned IRQ_ENABLE = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       irq,
    output logic [1:0] aluControl,
    output logic [1:0] aluSrcB,
    output logic       ALUSrcA,
    output logic       PCSource,
    output logic       PCWrite,
    output logic       isBranch,
    output logic       lorD,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       isInterrupted,
    output logic       irqAck,
    output logic       illegalOp
);

    localparam bit IRQ_EN = (IRQ_ENABLE != 0);

    state_t     state_q;
    state_t     state_d;
    logic [1:0] alu_op;
    logic [1:0] dec_alu_ctrl;
    logic       funct_illegal;
    logic       set_illegal;
    logic       irq_prev_q;
    logic       irq_pending_q;
    logic       illegal_q;
    logic       irq_rise;

    alu_op_decoder u_alu_op_decoder (
        .aluOp        (alu_op),
        .funct        (funct),
        .aluControl   (dec_alu_ctrl),
        .functIllegal (funct_illegal)
    );

    // ALU operation class is a pure function of the state.
    always_comb begin
        alu_op = ALUOP_ADD;
        case (state_q)
            S_EXECUTE: alu_op = ALUOP_FUNCT;
            S_BRANCH:  alu_op = ALUOP_SUB;
            default:   alu_op = ALUOP_ADD;
        endcase
    end

    // State register; reset aborts any instruction in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= S_FETCH;
        else        state_q <= state_d;
    end

    // Next-state and Moore strobes; everything is held low while reset is asserted.
    always_comb begin
        state_d       = state_q;
        set_illegal   = 1'b0;
        aluSrcB       = SRCB_B;
        ALUSrcA       = 1'b0;
        PCSource      = 1'b0;
        PCWrite       = 1'b0;
        isBranch      = 1'b0;
        lorD          = 1'b0;
        MemWrite      = 1'b0;
        IRWrite       = 1'b0;
        RegWrite      = 1'b0;
        RegDst        = 1'b0;
        MemtoReg      = 1'b0;
        isInterrupted = 1'b0;
        irqAck        = 1'b0;
        case (state_q)
            S_FETCH: begin
                IRWrite       = 1'b1;
                PCWrite       = 1'b1;
                aluSrcB       = SRCB_FOUR;
                isInterrupted = irq_pending_q;
                irqAck        = irq_pending_q;
                state_d       = S_DECODE;
            end
            S_DECODE: begin
                aluSrcB = SRCB_IMM_SH;
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXECUTE;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_ADDI:      state_d = S_ADDIEXEC;
                    default: begin
                        state_d     = S_FETCH;
                        set_illegal = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                ALUSrcA = 1'b1;
                aluSrcB = SRCB_IMM;
                state_d = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                lorD    = 1'b1;
                state_d = S_MEMWB;
            end
            S_MEMWB: begin
                MemtoReg = 1'b1;
                RegWrite = 1'b1;
                state_d  = S_FETCH;
            end
            S_MEMWRITE: begin
                lorD     = 1'b1;
                MemWrite = 1'b1;
                state_d  = S_FETCH;
            end
            S_EXECUTE: begin
                ALUSrcA = 1'b1;
                aluSrcB = SRCB_B;
                if (funct_illegal) begin
                    state_d     = S_FETCH;
                    set_illegal = 1'b1;
                end else begin
                    state_d = S_ALUWB;
                end
            end
            S_ALUWB: begin
                RegDst   = 1'b1;
                RegWrite = 1'b1;
                state_d  = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcA  = 1'b1;
                aluSrcB  = SRCB_B;
                isBranch = 1'b1;
                PCSource = 1'b1;
                state_d  = S_FETCH;
            end
            S_ADDIEXEC: begin
                ALUSrcA = 1'b1;
                aluSrcB = SRCB_IMM;
                state_d = S_ADDIWB;
            end
            S_ADDIWB: begin
                RegWrite = 1'b1;
                state_d  = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
        if (!rst_n) begin
            set_illegal   = 1'b0;
            aluSrcB       = SRCB_B;
            ALUSrcA       = 1'b0;
            PCSource      = 1'b0;
            PCWrite       = 1'b0;
            isBranch      = 1'b0;
            lorD          = 1'b0;
            MemWrite      = 1'b0;
            IRWrite       = 1'b0;
            RegWrite      = 1'b0;
            RegDst        = 1'b0;
            MemtoReg      = 1'b0;
            isInterrupted = 1'b0;
            irqAck        = 1'b0;
        end
    end

    assign aluControl = rst_n ? dec_alu_ctrl : ALU_ADD;
    assign illegalOp  = illegal_q & rst_n;
    assign irq_rise   = IRQ_EN & irq & ~irq_prev_q;

    // Interrupt edge latch; a new edge beats the acknowledge clear so it is not lost.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            irq_prev_q    <= 1'b0;
            irq_pending_q <= 1'b0;
        end else begin
            irq_prev_q <= irq & IRQ_EN;
            if (irq_rise)    irq_pending_q <= 1'b1;
            else if (irqAck) irq_pending_q <= 1'b0;
        end
    end

    // Sticky illegal-instruction flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (!rst_n)           illegal_q <= 1'b0;
        else if (set_illegal) illegal_q <= 1'b1;
    end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Cycle-by-cycle directed vectors for the multicycle controller, plus an irq-held ack count.
module tb_multicycle_control_unit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] op;
    logic [5:0] funct;
    logic       irq;
    logic [1:0] aluControl;
    logic [1:0] aluSrcB;
    logic       ALUSrcA, PCSource, PCWrite, isBranch, lorD, MemWrite, IRWrite;
    logic       RegWrite, RegDst, MemtoReg, isInterrupted, irqAck, illegalOp;

    multicycle_control_unit dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .op            (op),
        .funct         (funct),
        .irq           (irq),
        .aluControl    (aluControl),
        .aluSrcB       (aluSrcB),
        .ALUSrcA       (ALUSrcA),
        .PCSource      (PCSource),
        .PCWrite       (PCWrite),
        .isBranch      (isBranch),
        .lorD          (lorD),
        .MemWrite      (MemWrite),
        .IRWrite       (IRWrite),
        .RegWrite      (RegWrite),
        .RegDst        (RegDst),
        .MemtoReg      (MemtoReg),
        .isInterrupted (isInterrupted),
        .irqAck        (irqAck),
        .illegalOp     (illegalOp)
    );

    always #5 clk = ~clk;

    // Expected vector layout: {aluControl, aluSrcB, ALUSrcA, PCSource, PCWrite, isBranch,
    // lorD, MemWrite, IRWrite, RegWrite, RegDst, MemtoReg, isInterrupted, irqAck, illegalOp}
    localparam logic [16:0] A_SUB  = 17'h08000;
    localparam logic [16:0] A_AND  = 17'h10000;
    localparam logic [16:0] A_OR   = 17'h18000;
    localparam logic [16:0] B_FOUR = 17'h02000;
    localparam logic [16:0] B_IMM  = 17'h04000;
    localparam logic [16:0] B_IMSH = 17'h06000;
    localparam logic [16:0] SRCA   = 17'h01000;
    localparam logic [16:0] PCSRC  = 17'h00800;
    localparam logic [16:0] PCW    = 17'h00400;
    localparam logic [16:0] BR     = 17'h00200;
    localparam logic [16:0] LORD   = 17'h00100;
    localparam logic [16:0] MW     = 17'h00080;
    localparam logic [16:0] IRW    = 17'h00040;
    localparam logic [16:0] RW     = 17'h00020;
    localparam logic [16:0] RD     = 17'h00010;
    localparam logic [16:0] M2R    = 17'h00008;
    localparam logic [16:0] INTR   = 17'h00004;
    localparam logic [16:0] ACK    = 17'h00002;
    localparam logic [16:0] ILL    = 17'h00001;

    localparam logic [16:0] E_F    = B_FOUR | PCW | IRW;
    localparam logic [16:0] E_FI   = E_F | INTR | ACK;
    localparam logic [16:0] E_D    = B_IMSH;
    localparam logic [16:0] E_MA   = B_IMM | SRCA;
    localparam logic [16:0] E_MR   = LORD;
    localparam logic [16:0] E_MWB  = M2R | RW;
    localparam logic [16:0] E_MW   = LORD | MW;
    localparam logic [16:0] E_EX   = SRCA;
    localparam logic [16:0] E_AWB  = RD | RW;
    localparam logic [16:0] E_BR   = A_SUB | SRCA | BR | PCSRC;
    localparam logic [16:0] E_AE   = B_IMM | SRCA;
    localparam logic [16:0] E_AIW  = RW;

    localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
    localparam logic [5:0] BQ = 6'b000100, AI = 6'b001000, XX = 6'b111111;
    localparam logic [5:0] FADD = 6'b100000, FSUB = 6'b100010, FAND = 6'b100100;
    localparam logic [5:0] FOR  = 6'b100101, FBAD = 6'b101010;

    typedef struct {
        logic        rst_n;
        logic [5:0]  op;
        logic [5:0]  funct;
        logic        irq;
        logic [16:0] exp;
        string       name;
    } vec_t;

    vec_t vecs[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic add(input logic r, input logic [5:0] o, input logic [5:0] f,
                       input logic i, input logic [16:0] e, input string n);
        vec_t v;
        v.rst_n = r; v.op = o; v.funct = f; v.irq = i; v.exp = e; v.name = n;
        vecs.push_back(v);
    endtask

    function automatic logic [16:0] actual();
        return {aluControl, aluSrcB, ALUSrcA, PCSource, PCWrite, isBranch, lorD, MemWrite,
                IRWrite, RegWrite, RegDst, MemtoReg, isInterrupted, irqAck, illegalOp};
    endfunction

    initial begin
        rst_n = 1'b0; op = '0; funct = '0; irq = 1'b0;

        // reset held two cycles with irq high
        add(0, LW, 0, 1, '0, "rst_a");
        add(0, LW, 0, 1, '0, "rst_b");
        // lw
        add(1, LW, 0, 0, E_F,   "lw_fetch");
        add(1, LW, 0, 0, E_D,   "lw_decode");
        add(1, LW, 0, 0, E_MA,  "lw_memadr");
        add(1, LW, 0, 0, E_MR,  "lw_memread");
        add(1, LW, 0, 0, E_MWB, "lw_memwb");
        // sw
        add(1, SW, 0, 0, E_F,   "sw_fetch");
        add(1, SW, 0, 0, E_D,   "sw_decode");
        add(1, SW, 0, 0, E_MA,  "sw_memadr");
        add(1, SW, 0, 0, E_MW,  "sw_memwrite");
        // R-type sub / and / or
        add(1, RT, FSUB, 0, E_F,          "sub_fetch");
        add(1, RT, FSUB, 0, E_D,          "sub_decode");
        add(1, RT, FSUB, 0, E_EX | A_SUB, "sub_exec");
        add(1, RT, FSUB, 0, E_AWB,        "sub_aluwb");
        add(1, RT, FAND, 0, E_F,          "and_fetch");
        add(1, RT, FAND, 0, E_D,          "and_decode");
        add(1, RT, FAND, 0, E_EX | A_AND, "and_exec");
        add(1, RT, FAND, 0, E_AWB,        "and_aluwb");
        add(1, RT, FOR,  0, E_F,          "or_fetch");
        add(1, RT, FOR,  0, E_D,          "or_decode");
        add(1, RT, FOR,  0, E_EX | A_OR,  "or_exec");
        add(1, RT, FOR,  0, E_AWB,        "or_aluwb");
        // beq, addi
        add(1, BQ, 0, 0, E_F,   "beq_fetch");
        add(1, BQ, 0, 0, E_D,   "beq_decode");
        add(1, BQ, 0, 0, E_BR,  "beq_branch");
        add(1, AI, 0, 0, E_F,   "addi_fetch");
        add(1, AI, 0, 0, E_D,   "addi_decode");
        add(1, AI, 0, 0, E_AE,  "addi_exec");
        add(1, AI, 0, 0, E_AIW, "addi_wb");
        // irq pulse during lw MEMADR: serviced only at the next FETCH
        add(1, LW, 0, 0, E_F,   "irqlw_fetch");
        add(1, LW, 0, 0, E_D,   "irqlw_decode");
        add(1, LW, 0, 1, E_MA,  "irqlw_memadr");
        add(1, LW, 0, 0, E_MR,  "irqlw_memread");
        add(1, LW, 0, 0, E_MWB, "irqlw_memwb");
        add(1, AI, 0, 0, E_FI,  "irq_ack_fetch");
        add(1, AI, 0, 0, E_D,   "irq_addi_decode");
        add(1, AI, 0, 0, E_AE,  "irq_addi_exec");
        add(1, AI, 0, 0, E_AIW, "irq_addi_wb");
        // irq held high: a single acknowledge
        add(1, BQ, 0, 1, E_F,   "hold_fetch0");
        add(1, BQ, 0, 1, E_D,   "hold_decode0");
        add(1, BQ, 0, 1, E_BR,  "hold_branch0");
        add(1, BQ, 0, 1, E_FI,  "hold_ack");
        add(1, BQ, 0, 1, E_D,   "hold_decode1");
        add(1, BQ, 0, 1, E_BR,  "hold_branch1");
        add(1, BQ, 0, 0, E_F,   "hold_noack");
        // new edge in the same cycle as an ack: set wins, serviced again
        add(1, BQ, 0, 1, E_D,   "sc_decode0");
        add(1, BQ, 0, 0, E_BR,  "sc_branch0");
        add(1, BQ, 0, 1, E_FI,  "sc_ack_and_edge");
        add(1, BQ, 0, 0, E_D,   "sc_decode1");
        add(1, BQ, 0, 0, E_BR,  "sc_branch1");
        add(1, BQ, 0, 0, E_FI,  "sc_second_ack");
        add(1, BQ, 0, 0, E_D,   "sc_decode2");
        add(1, BQ, 0, 0, E_BR,  "sc_branch2");
        // illegal funct, then reset in the middle of a lw
        add(1, RT, FBAD, 0, E_F,       "badf_fetch");
        add(1, RT, FBAD, 0, E_D,       "badf_decode");
        add(1, RT, FBAD, 0, E_EX,      "badf_exec");
        add(1, LW, 0,    0, E_F | ILL, "badf_fetch_ill");
        add(1, LW, 0,    0, E_D | ILL, "ill_lw_decode");
        add(1, LW, 0,    0, E_MA | ILL,"ill_lw_memadr");
        add(0, LW, 0,    0, '0,        "rst_mid_lw");
        // illegal opcode: FETCH, DECODE, FETCH; flag sticks until reset
        add(1, XX, 0,    0, E_F,        "xop_fetch");
        add(1, XX, 0,    0, E_D,        "xop_decode");
        add(1, XX, 0,    0, E_F | ILL,  "xop_fetch_ill");
        add(1, XX, 0,    0, E_D | ILL,  "xop_decode_ill");
        add(1, RT, FADD, 0, E_F | ILL,  "add_fetch_ill");
        add(1, RT, FADD, 0, E_D | ILL,  "add_decode_ill");
        add(1, RT, FADD, 0, E_EX | ILL, "add_exec_ill");
        add(1, RT, FADD, 0, E_AWB | ILL,"add_aluwb_ill");
        add(1, RT, FADD, 0, E_F | ILL,  "ill_sticky_fetch");
        add(0, BQ, 0,    0, '0,         "rst_clear");
        add(1, BQ, 0,    0, E_F,        "post_rst_fetch");

        for (int k = 0; k < vecs.size(); k++) begin
            @(negedge clk);
            rst_n = vecs[k].rst_n;
            op    = vecs[k].op;
            funct = vecs[k].funct;
            irq   = vecs[k].irq;
            #1;
            checks++;
            if (actual() !== vecs[k].exp) begin
                failures++;
                $display("FAIL row%0d %s got=%05h exp=%05h", k, vecs[k].name, actual(), vecs[k].exp);
            end
        end

        // irq held high across many beq instructions yields exactly one acknowledge
        begin
            int acks = 0;
            int ints = 0;
            for (int c = 0; c < 30; c++) begin
                @(negedge clk);
                op  = BQ;
                irq = 1'b1;
                #1;
                if (irqAck === 1'b1) acks++;
                if (isInterrupted === 1'b1) ints++;
            end
            checks++;
            if (acks != 1) begin
                failures++;
                $display("FAIL held_irq_ack_count got=%0d exp=1", acks);
            end
            checks++;
            if (ints != 1) begin
                failures++;
                $display("FAIL held_irq_int_count got=%0d exp=1", ints);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
- Multicycle MIPS controller: the decode end of the datapath's control interface.
- Consumes op/funct from the datapath's instruction register; drives every datapath control strobe, one instruction per 3–5 cycles.
- Moore FSM plus ALU-operation decoder and an edge-triggered interrupt latch.
- Sits beside the datapath in the CPU top level; the two share clk.

Parameters:
- IRQ_ENABLE, 1, 0 ties isInterrupted/irqAck low and ignores irq.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  synchronous active-low reset; one clock, reset synchronous and active-low
- op  in  6  instruction opcode from datapath
- funct  in  6  R-type function field from datapath
- irq  in  1  external interrupt request, level, synchronous to clk
- aluControl  out  2  ALU operation: 00 ADD, 01 SUB, 10 AND, 11 OR
- aluSrcB  out  2  00 B reg, 01 const 4, 10 signImm, 11 signImm<<2
- ALUSrcA  out  1  0 PC, 1 A reg
- PCSource  out  1  0 aluResult, 1 ALUOut
- PCWrite, isBranch, lorD, MemWrite, IRWrite, RegWrite, RegDst, MemtoReg  out  1 each  datapath strobes
- isInterrupted  out  1  redirect fetch to interrupt vector
- irqAck  out  1  one-cycle acknowledge
- illegalOp  out  1  sticky: unsupported op/funct seen

Behaviour:
- State register 4 bits. States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTE, ALUWB, BRANCH, ADDIEXEC, ADDIWB.
- Outputs are a combinational function of the registered state (Moore). Exception: aluControl in EXECUTE is decoded from funct.
- Any output not listed for a state is 0.
- Reset (rst_n=0 at a clk edge):
  - state<=FETCH, irqPending<=0, irqPrev<=0, illegalOp<=0.
  - While rst_n=0, all outputs are forced to 0.
- FETCH:
  - IRWrite=1, PCWrite=1, aluSrcB=01, ADD.
  - isInterrupted=irqPending, irqAck=irqPending.
  - Next state: DECODE.
- DECODE: aluSrcB=11, ADD. Next state by op:
  - 100011 or 101011 -> MEMADR
  - 000000 -> EXECUTE
  - 000100 -> BRANCH
  - 001000 -> ADDIEXEC
  - other -> FETCH and set illegalOp
- MEMADR: ALUSrcA=1, aluSrcB=10, ADD. Next: MEMREAD if op=100011, else MEMWRITE.
- MEMREAD: lorD=1. Next: MEMWB.
- MEMWB: MemtoReg=1, RegWrite=1. Next: FETCH.
- MEMWRITE: lorD=1, MemWrite=1. Next: FETCH.
- EXECUTE: ALUSrcA=1, aluSrcB=00. funct decode:
  - 100000 -> ADD, 100010 -> SUB, 100100 -> AND, 100101 -> OR.
  - Other funct: ADD, set illegalOp, and go to FETCH with no writeback.
  - Supported funct: next state ALUWB.
- ALUWB: RegDst=1, RegWrite=1. Next: FETCH.
- BRANCH: ALUSrcA=1, aluSrcB=00, SUB, isBranch=1, PCSource=1. Next: FETCH.
- ADDIEXEC: ALUSrcA=1, aluSrcB=10, ADD. Next: ADDIWB.
- ADDIWB: RegWrite=1. Next: FETCH.
- Latency in cycles: lw 5, sw 4, R-type 4, addi 4, beq 3, illegal 2.
- Interrupt handling:
  - irqPrev<=irq every cycle. Rising edge = irq & ~irqPrev.
  - irqPending set on a rising edge; cleared at the end of a FETCH cycle with irqAck=1.
  - Set and clear in the same cycle: set wins, so the pending edge is serviced on the next instruction.
  - An interrupt never aborts a multicycle instruction; it is taken only at the next FETCH.
- illegalOp clears only on reset.
- Reset mid-instruction aborts it immediately. No strobe is asserted in the reset cycle, and the first post-reset cycle is FETCH.

Decomposition:
- Shared package cpu_ctrl_pkg holds:
  - state enum
  - opcode constants OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI
  - funct constants
  - ALU_ADD/SUB/AND/OR encodings
  - SRCB_* encodings
- One sub-module: alu_op_decoder. Inputs: a 2-bit aluOp class (add/sub/funct) and funct. Outputs: aluControl and functIllegal.

Test Plan:
- Reset: rst_n=0 for 2 cycles with irq=1 -> all outputs 0. First cycle after release: IRWrite=1, PCWrite=1, aluSrcB=01, irqAck=0.
- lw (op=100011) -> strobe sequence FETCH, DECODE, MEMADR (aluSrcB=10), MEMREAD (lorD=1), MEMWB (MemtoReg=1, RegWrite=1), then FETCH; 5 cycles. sw (op=101011) -> MemWrite=1 on cycle 4, back to FETCH on cycle 5.
- R-type: op=0 with funct 100010, 100100, 100101 -> aluControl 01/10/11 in EXECUTE, then ALUWB with RegDst=1, RegWrite=1. funct=101010 -> illegalOp=1, no RegWrite, FETCH after EXECUTE.
- beq (op=000100) -> BRANCH cycle: isBranch=1, PCSource=1, aluControl=01, PCWrite=0. addi (op=001000) -> ADDIWB: RegWrite=1, RegDst=0, MemtoReg=0.
- irq pulse during MEMADR of lw -> no change until the next FETCH, which has isInterrupted=1 and irqAck=1 for exactly one cycle; the following FETCH has irqAck=0. irq held high -> only one ack.
- op=111111 -> FETCH, DECODE, FETCH; illegalOp goes and stays 1 until rst_n=0.
